// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, store-type encodings and default line size for the data-memory refill controller
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_STORE, S_REFILL, S_DONE} state_e;
  localparam logic [2:0] ST_SB = 3'b001;
  localparam logic [2:0] ST_SH = 3'b010;
  localparam logic [2:0] ST_SW = 3'b100;
  localparam int LINE_WORDS_DEF = 4;
  function automatic logic is_store_type(input logic [2:0] t);
    return t == ST_SB || t == ST_SH || t == ST_SW;
  endfunction
endpackage

// File: rtl/mem_store_align.sv
// mem_store_align: byte enables and lane replication for sub-word stores
module mem_store_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  st_type,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);
  always_comb begin
    be_o    = st_type == ST_SW ? 4'b1111 :
              st_type == ST_SH ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
              st_type == ST_SB ? 4'b0001 << addr_lo : 4'b0000;
    wdata_o = st_type == ST_SW ? wdata_i :
              st_type == ST_SH ? {2{wdata_i[15:0]}} :
              st_type == ST_SB ? {4{wdata_i[7:0]}} : 32'h0;
  end
endmodule

// File: rtl/dmem_refill_ctrl.sv
// dmem_refill_ctrl: write-through store path and line refill sequencer between the M stage and backing memory
module dmem_refill_ctrl
  import dmem_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  MemWriteM_i,
  input  logic        MemReadM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  input  logic        cache_hit_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        refill_valid_o,
  output logic [31:0] refill_addr_o,
  output logic [31:0] refill_data_o,
  output logic        refill_last_o,
  output logic        mem_ready_o
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [2:0] type_q, type_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic refill_valid_q, refill_valid_d, refill_last_q, refill_last_d;
  logic [31:0] refill_addr_q, refill_addr_d, refill_data_q, refill_data_d;
  logic is_store, is_miss, start;
  logic [3:0] st_be;
  logic [31:0] st_wdata, fill_addr;
  assign is_store = is_store_type(MemWriteM_i);
  assign is_miss = MemReadM_i && !cache_hit_i;
  assign start = is_store || is_miss;
  assign mem_ready_o = state_q == S_IDLE && !start;
  // counter is spliced into the offset field, so the address can never carry into the tag
  assign fill_addr = {addr_q[31:CW+2], cnt_q, 2'b00};
  assign refill_valid_o = refill_valid_q;
  assign refill_last_o = refill_last_q;
  assign refill_addr_o = refill_addr_q;
  assign refill_data_o = refill_data_q;
  mem_store_align u_align (
    .addr_lo (addr_q[1:0]),
    .st_type (type_q),
    .wdata_i (data_q),
    .be_o    (st_be),
    .wdata_o (st_wdata)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    type_d = type_q;
    cnt_d = cnt_q;
    refill_valid_d = 1'b0;
    refill_last_d = 1'b0;
    refill_addr_d = refill_addr_q;
    refill_data_d = refill_data_q;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    mem_addr_o = 32'h0;
    mem_wdata_o = 32'h0;
    mem_be_o = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (is_store) begin
          addr_d = ALUResultM_i;
          data_d = WriteDataM_i;
          type_d = MemWriteM_i;
          state_d = S_STORE;
        end else if (is_miss) begin
          addr_d = ALUResultM_i & ~32'(LINE_WORDS * 4 - 1);
          cnt_d = '0;
          state_d = S_REFILL;
        end
      end
      S_STORE: begin
        mem_req_o = 1'b1;
        mem_we_o = 1'b1;
        mem_addr_o = {addr_q[31:2], 2'b00};
        mem_wdata_o = st_wdata;
        mem_be_o = st_be;
        state_d = mem_ack_i ? S_DONE : S_STORE;
      end
      S_REFILL: begin
        mem_req_o = 1'b1;
        mem_addr_o = fill_addr;
        if (mem_ack_i) begin
          refill_valid_d = 1'b1;
          refill_last_d = cnt_q == LAST;
          refill_addr_d = fill_addr;
          refill_data_d = mem_rdata_i;
          cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 1'b1;
          state_d = cnt_q == LAST ? S_DONE : S_REFILL;
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q <= 32'h0;
      data_q <= 32'h0;
      type_q <= 3'b000;
      cnt_q <= '0;
      refill_valid_q <= 1'b0;
      refill_last_q <= 1'b0;
      refill_addr_q <= 32'h0;
      refill_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      type_q <= type_d;
      cnt_q <= cnt_d;
      refill_valid_q <= refill_valid_d;
      refill_last_q <= refill_last_d;
      refill_addr_q <= refill_addr_d;
      refill_data_q <= refill_data_d;
    end
  end
endmodule

// File: tb/tb_dmem_refill_ctrl.sv
// tb_dmem_refill_ctrl: directed and randomized transaction-level checks of the refill controller
module tb_dmem_refill_ctrl;
  localparam int LW = 4;
  localparam logic [2:0] T_SB = 3'b001, T_SH = 3'b010, T_SW = 3'b100;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] MemWriteM_i = 3'b000;
  logic MemReadM_i = 1'b0, cache_hit_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] ALUResultM_i = 32'h0, WriteDataM_i = 32'h0, mem_rdata_i = 32'h0;
  logic mem_req_o, mem_we_o, refill_valid_o, refill_last_o, mem_ready_o;
  logic [31:0] mem_addr_o, mem_wdata_o, refill_addr_o, refill_data_o;
  logic [3:0] mem_be_o;
  int compared = 0, mismatched = 0;

  dmem_refill_ctrl #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n), .MemWriteM_i(MemWriteM_i), .MemReadM_i(MemReadM_i),
    .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i), .cache_hit_i(cache_hit_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .refill_valid_o(refill_valid_o), .refill_addr_o(refill_addr_o),
    .refill_data_o(refill_data_o), .refill_last_o(refill_last_o), .mem_ready_o(mem_ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    MemWriteM_i = 3'b000;
    MemReadM_i = 1'b0;
    cache_hit_i = 1'b0;
    ALUResultM_i = $urandom;
    WriteDataM_i = $urandom;
    mem_ack_i = 1'b0;
  endtask

  task automatic junk_in();
    MemWriteM_i = 3'($urandom);
    MemReadM_i = 1'($urandom);
    cache_hit_i = 1'($urandom);
    ALUResultM_i = $urandom;
    WriteDataM_i = $urandom;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(mem_req_o), 0);
    chk({tag, "_we"}, 32'(mem_we_o), 0);
    chk({tag, "_be"}, 32'(mem_be_o), 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_rv"}, 32'(refill_valid_o), 0);
    chk({tag, "_rlast"}, 32'(refill_last_o), 0);
    chk({tag, "_raddr"}, refill_addr_o, 0);
    chk({tag, "_rdata"}, refill_data_o, 0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                          input logic rd, input int lat);
    logic [3:0] be;
    logic [31:0] wd;
    int off;
    off = int'(a[1:0]);
    be = t == T_SW ? 4'hF : t == T_SH ? (off >= 2 ? 4'hC : 4'h3) : 4'(1 << off);
    wd = t == T_SW ? d : t == T_SH ? {16'h0, d[15:0]} * 32'h00010001 : {24'h0, d[7:0]} * 32'h01010101;
    @(negedge clk);
    MemWriteM_i = t; MemReadM_i = rd; cache_hit_i = 1'b0;
    ALUResultM_i = a; WriteDataM_i = d; mem_ack_i = 1'($urandom);
    #1 chk("st_ready_start", 32'(mem_ready_o), 0);
    chk("st_req_idle", 32'(mem_req_o), 0);
    for (int w = 0; w <= lat; w++) begin
      @(negedge clk);
      junk_in();
      mem_ack_i = w == lat;
      mem_rdata_i = $urandom;
      #1 chk("st_req", 32'(mem_req_o), 1);
      chk("st_we", 32'(mem_we_o), 1);
      chk("st_addr", mem_addr_o, a & 32'hFFFF_FFFC);
      chk("st_be", 32'(mem_be_o), 32'(be));
      chk("st_wdata", mem_wdata_o, wd);
      chk("st_ready", 32'(mem_ready_o), 0);
      chk("st_no_refill", 32'(refill_valid_o), 0);
    end
    @(negedge clk);
    junk_in();
    mem_ack_i = 1'($urandom);
    #1 chk("st_done_req", 32'(mem_req_o), 0);
    chk("st_done_ready", 32'(mem_ready_o), 0);
    chk("st_done_rv", 32'(refill_valid_o), 0);
    @(negedge clk);
    idle_in();
    #1 chk("st_after_ready", 32'(mem_ready_o), 1);
    chk("st_after_req", 32'(mem_req_o), 0);
  endtask

  task automatic do_refill(input logic [31:0] a, input int lat_min, input int lat_max, input bit abort);
    logic [31:0] base;
    logic [31:0] dq[$];
    int lat;
    base = a & ~32'(LW * 4 - 1);
    @(negedge clk);
    MemWriteM_i = 1'($urandom) ? 3'b011 : 3'b000;
    MemReadM_i = 1'b1; cache_hit_i = 1'b0;
    ALUResultM_i = a; WriteDataM_i = $urandom; mem_ack_i = 1'($urandom);
    #1 chk("rf_ready_start", 32'(mem_ready_o), 0);
    chk("rf_req_idle", 32'(mem_req_o), 0);
    for (int i = 0; i < LW; i++) begin
      lat = $urandom_range(lat_min, lat_max);
      for (int w = 0; w <= lat; w++) begin
        @(negedge clk);
        junk_in();
        mem_ack_i = w == lat;
        mem_rdata_i = $urandom;
        if (abort && i == 2 && w == 0) begin
          rst_n = 1'b0;
          #1 chk_reset_vals("abort");
          return;
        end
        #1 chk("rf_req", 32'(mem_req_o), 1);
        chk("rf_we", 32'(mem_we_o), 0);
        chk("rf_addr", mem_addr_o, base + 32'(4 * i));
        chk("rf_ready", 32'(mem_ready_o), 0);
        chk("rf_valid", 32'(refill_valid_o), 32'(i > 0 && w == 0));
        if (i > 0 && w == 0) begin
          chk("rf_beat_addr", refill_addr_o, base + 32'(4 * (i - 1)));
          chk("rf_beat_data", refill_data_o, dq[i - 1]);
          chk("rf_beat_last", 32'(refill_last_o), 0);
        end
        if (w == lat) dq.push_back(mem_rdata_i);
      end
    end
    @(negedge clk);
    junk_in();
    mem_ack_i = 1'($urandom);
    #1 chk("rf_done_req", 32'(mem_req_o), 0);
    chk("rf_done_ready", 32'(mem_ready_o), 0);
    chk("rf_last_valid", 32'(refill_valid_o), 1);
    chk("rf_last_addr", refill_addr_o, base + 32'(4 * (LW - 1)));
    chk("rf_last_data", refill_data_o, dq[LW - 1]);
    chk("rf_last_flag", 32'(refill_last_o), 1);
    @(negedge clk);
    idle_in();
    #1 chk("rf_after_ready", 32'(mem_ready_o), 1);
    chk("rf_after_rv", 32'(refill_valid_o), 0);
    chk("rf_after_req", 32'(mem_req_o), 0);
  endtask

  task automatic do_hit(input logic [31:0] a);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      MemWriteM_i = 1'($urandom) ? 3'b111 : 3'b000;
      MemReadM_i = 1'b1; cache_hit_i = 1'b1;
      ALUResultM_i = a; mem_ack_i = 1'($urandom);
      #1 chk("hit_ready", 32'(mem_ready_o), 1);
      chk("hit_req", 32'(mem_req_o), 0);
    end
  endtask

  initial begin
    logic [2:0] types [3];
    int kind;
    types[0] = T_SB; types[1] = T_SH; types[2] = T_SW;
    idle_in();
    repeat (2) @(negedge clk);
    #1 chk_reset_vals("reset");
    chk("reset_ready", 32'(mem_ready_o), 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_store(32'h0000_0102, 32'h0000_00AB, T_SB, 1'b0, 0);
    do_store(32'h0000_0102, 32'h0000_00AB, T_SB, 1'b0, 2);
    do_refill(32'h0000_104C, 0, 0, 1'b0);
    do_refill(32'h0000_2008, 3, 3, 1'b0);
    do_store(32'h0000_3003, 32'hDEAD_BEEF, T_SW, 1'b1, 1);
    do_store(32'h0000_3002, 32'h1234_5678, T_SH, 1'b0, 0);
    do_hit(32'h0000_4000);
    do_refill(32'h0000_5010, 0, 2, 1'b1);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle_in();
      mem_ack_i = 1'($urandom);
      #1 chk("post_abort_rv", 32'(refill_valid_o), 0);
      chk("post_abort_req", 32'(mem_req_o), 0);
    end
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0)
        do_store($urandom, $urandom, types[$urandom_range(0, 2)], 1'($urandom), $urandom_range(0, 3));
      else if (kind == 1)
        do_refill($urandom, 0, 3, 1'b0);
      else if (kind == 2)
        do_hit($urandom);
      else begin
        @(negedge clk);
        MemWriteM_i = 3'b011; MemReadM_i = 1'b0; cache_hit_i = 1'($urandom);
        ALUResultM_i = $urandom; mem_ack_i = 1'($urandom);
        #1 chk("none_ready", 32'(mem_ready_o), 1);
        chk("none_req", 32'(mem_req_o), 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
